// File: rtl/inst_fetch_if.sv
// Instruction-memory read channel between the fetch unit and memory.
// master: fetch side (issues requests); slave: memory side (returns data).
interface inst_fetch_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_rdata,
        output mem_ack
    );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch unit: reads one instruction at a time from instruction
// memory, hands it to decode, and drives the next-PC write (sequential +4 or
// redirect target). Responses that arrive after a redirect are dropped.
// Optional feature macro: FETCH_MISALIGN_CHK_EN (sticky misaligned-redirect flag).
module inst_fetch (
    input  logic         clk,
    input  logic         reset,
    input  logic [31:0]  pc_i,
    output logic         PCWrite,
    output logic [31:0]  PC_next,
    inst_fetch_if.master mem,
    output logic [31:0]  inst_o,
    output logic [31:0]  inst_pc_o,
    output logic         inst_valid,
    input  logic         id_ready,
    input  logic         redirect,
    input  logic [31:0]  redirect_target,
    output logic         misalign_o
);

    typedef enum logic [1:0] {ISSUE, WAIT, HOLD, DRAIN} state_t;

    state_t      state;
    logic [31:0] addr;
    logic [31:0] tgt_aligned;

    // Redirect targets are always forced to a word boundary.
    assign tgt_aligned = {redirect_target[31:2], 2'b00};

    // A request is outstanding exactly while waiting for or draining a response.
    assign mem.mem_req  = !reset && ((state == WAIT) || (state == DRAIN));
    assign mem.mem_addr = addr;

    // Next-PC write: a redirect wins over the sequential +4 of a completed fetch.
    always_comb begin
        PCWrite = 1'b0;
        PC_next = addr + 32'd4;
        if (!reset) begin
            if (redirect) begin
                PCWrite = 1'b1;
                PC_next = tgt_aligned;
            end else if ((state == WAIT) && mem.mem_ack) begin
                PCWrite = 1'b1;
            end
        end
    end

    // Fetch FSM with registered handoff outputs to decode.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ISSUE;
            addr       <= 32'd0;
            inst_o     <= 32'd0;
            inst_pc_o  <= 32'd0;
            inst_valid <= 1'b0;
        end else begin
            case (state)
                ISSUE: begin
                    // On redirect the PC register is being rewritten; latch it next cycle.
                    if (!redirect) begin
                        addr  <= pc_i;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem.mem_ack) begin
                        if (redirect) begin
                            state <= ISSUE;
                        end else begin
                            inst_o     <= mem.mem_rdata;
                            inst_pc_o  <= addr;
                            inst_valid <= 1'b1;
                            state      <= HOLD;
                        end
                    end else if (redirect) begin
                        // Response is still owed; swallow it before refetching.
                        state <= DRAIN;
                    end
                end
                HOLD: begin
                    if (redirect || id_ready) begin
                        inst_valid <= 1'b0;
                        state      <= ISSUE;
                    end
                end
                DRAIN: begin
                    if (mem.mem_ack) begin
                        state <= ISSUE;
                    end
                end
                default: state <= ISSUE;
            endcase
        end
    end

`ifdef FETCH_MISALIGN_CHK_EN
    // Sticky flag: any redirect to a non-word-aligned target, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            misalign_o <= 1'b0;
        end else if (redirect && (redirect_target[1:0] != 2'b00)) begin
            misalign_o <= 1'b1;
        end
    end
`else
    logic unused_tgt_bits;
    assign unused_tgt_bits = ^redirect_target[1:0];
    assign misalign_o      = 1'b0;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios followed by random
// redirect / back-pressure / memory-latency traffic checked against an
// instruction-stream reference model.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc_reg;
    logic        PCWrite;
    logic [31:0] PC_next;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_valid;
    logic        id_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_target = 32'd0;
    logic        misalign_o;

    inst_fetch_if bus ();

    inst_fetch dut (
        .clk             (clk),
        .reset           (reset),
        .pc_i            (pc_reg),
        .PCWrite         (PCWrite),
        .PC_next         (PC_next),
        .mem             (bus),
        .inst_o          (inst_o),
        .inst_pc_o       (inst_pc_o),
        .inst_valid      (inst_valid),
        .id_ready        (id_ready),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .misalign_o      (misalign_o)
    );

    always #5 clk = ~clk;

    // PC register outside the fetch unit
    always @(posedge clk) begin
        if (reset)        pc_reg <= 32'd0;
        else if (PCWrite) pc_reg <= PC_next;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'd0) return 32'h20080005;
        return (a * 32'h9E3779B1) ^ 32'h13572468;
    endfunction

    // Memory model state
    bit          busy = 0;
    int          left = 0;
    int          fixed_wait = -1;
    bit          stray_ack = 0;
    logic [31:0] req_addr = 32'd0;

    // Reference model state
    logic [31:0] exp_pc = 32'd0;
    bit          mis_flag = 0;
    bit          prev_valid = 0;
    bit          prev_pcw_plain = 0;
    logic [31:0] prev_pcnext = 32'd0;
    logic [31:0] prev_inst = 32'd0;
    logic [31:0] prev_ipc = 32'd0;

    task automatic model_step();
        bit rise;
        if (reset) begin
            check("rst_pcwrite", 32'(PCWrite), 32'd0);
            check("rst_memreq", 32'(bus.mem_req), 32'd0);
            exp_pc = 32'd0;
            mis_flag = 0;
            prev_valid = 0;
            prev_pcw_plain = 0;
            return;
        end
        rise = inst_valid && !prev_valid;
        check("dlv_follows_pcw", 32'(rise), 32'(prev_pcw_plain));
        if (rise) begin
            check("dlv_pc", inst_pc_o, exp_pc);
            check("dlv_inst", inst_o, mem_word(exp_pc));
            check("dlv_pcnext", prev_pcnext, inst_pc_o + 32'd4);
            exp_pc = exp_pc + 32'd4;
        end
        if (inst_valid && prev_valid) begin
            check("hold_inst", inst_o, prev_inst);
            check("hold_pc", inst_pc_o, prev_ipc);
            check("hold_memreq", 32'(bus.mem_req), 32'd0);
            check("hold_pcw", 32'(PCWrite), 32'(redirect));
        end
`ifdef FETCH_MISALIGN_CHK_EN
        check("misalign", 32'(misalign_o), 32'(mis_flag));
`else
        check("misalign_off", 32'(misalign_o), 32'd0);
`endif
        if (redirect) begin
            check("rd_pcw", 32'(PCWrite), 32'd1);
            check("rd_pcnext", PC_next, redirect_target & 32'hFFFF_FFFC);
            exp_pc = redirect_target & 32'hFFFF_FFFC;
            if (redirect_target[1:0] != 2'b00) mis_flag = 1;
        end
        prev_pcw_plain = PCWrite && !redirect;
        prev_pcnext    = PC_next;
        prev_valid     = inst_valid;
        prev_inst      = inst_o;
        prev_ipc       = inst_pc_o;
    endtask

    // One clock cycle: drive inputs, answer memory, then check at negedge.
    task automatic cycle(input logic rst_v, input logic rd, input logic [31:0] tgt, input logic idr);
        @(posedge clk);
        #1;
        reset = rst_v;
        redirect = rd;
        redirect_target = tgt;
        id_ready = idr;
        #1;
        bus.mem_ack = 1'b0;
        if (bus.mem_req) begin
            if (!busy) begin
                busy = 1;
                req_addr = bus.mem_addr;
                left = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 3));
            end else begin
                check("mem_addr_stable", bus.mem_addr, req_addr);
            end
            if (left == 0) begin
                bus.mem_ack = 1'b1;
                bus.mem_rdata = mem_word(req_addr);
                busy = 0;
            end else begin
                left--;
            end
        end else begin
            busy = 0;
            if (stray_ack) begin
                bus.mem_ack = 1'b1;
                bus.mem_rdata = 32'hDEADBEEF;
            end
        end
        @(negedge clk);
        model_step();
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b0, 32'd0, 1'b0);
        cycle(1'b1, 1'b0, 32'd0, 1'b0);
    endtask

    initial begin
        bus.mem_ack = 1'b0;
        bus.mem_rdata = 32'd0;

        // Basic fetch from 0 with one wait cycle
        fixed_wait = 1;
        do_reset();
        cycle(1'b0, 1'b0, 32'd0, 1'b0);
        check("t1_valid0", 32'(inst_valid), 32'd0);
        check("t1_inst0", inst_o, 32'd0);
        check("t1_ipc0", inst_pc_o, 32'd0);
        check("t1_req0", 32'(bus.mem_req), 32'd0);
        check("t1_mis0", 32'(misalign_o), 32'd0);
        cycle(1'b0, 1'b0, 32'd0, 1'b0);
        check("t1_req", 32'(bus.mem_req), 32'd1);
        check("t1_addr", bus.mem_addr, 32'd0);
        check("t1_nopcw", 32'(PCWrite), 32'd0);
        cycle(1'b0, 1'b0, 32'd0, 1'b0);
        check("t1_pcw", 32'(PCWrite), 32'd1);
        check("t1_pcnext", PC_next, 32'h4);
        cycle(1'b0, 1'b0, 32'd0, 1'b0);
        check("t1_valid", 32'(inst_valid), 32'd1);
        check("t1_inst", inst_o, 32'h20080005);
        check("t1_ipc", inst_pc_o, 32'd0);

        // Decode stalls for five cycles, then accepts
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b0, 32'd0, 1'b0);
            check("t2_valid", 32'(inst_valid), 32'd1);
            check("t2_inst", inst_o, 32'h20080005);
            check("t2_req", 32'(bus.mem_req), 32'd0);
            check("t2_pcw", 32'(PCWrite), 32'd0);
        end
        cycle(1'b0, 1'b0, 32'd0, 1'b1);
        cycle(1'b0, 1'b0, 32'd0, 1'b0);
        check("t2_valid_drop", 32'(inst_valid), 32'd0);
        cycle(1'b0, 1'b0, 32'd0, 1'b0);
        check("t2_req2", 32'(bus.mem_req), 32'd1);
        check("t2_addr2", bus.mem_addr, 32'h4);

        // Redirect while waiting, response three cycles later is dropped
        fixed_wait = 3;
        do_reset();
        cycle(1'b0, 1'b0, 32'd0, 1'b0);
        cycle(1'b0, 1'b1, 32'h100, 1'b0);
        check("t3_pcw", 32'(PCWrite), 32'd1);
        check("t3_pcnext", PC_next, 32'h100);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 32'd0, 1'b0);
            check("t3_drain_req", 32'(bus.mem_req), 32'd1);
            check("t3_drain_addr", bus.mem_addr, 32'd0);
            check("t3_drain_pcw", 32'(PCWrite), 32'd0);
        end
        cycle(1'b0, 1'b0, 32'd0, 1'b0);
        check("t3_dropped", 32'(inst_valid), 32'd0);
        check("t3_issue_req", 32'(bus.mem_req), 32'd0);
        cycle(1'b0, 1'b0, 32'd0, 1'b0);
        check("t3_refetch", bus.mem_addr, 32'h100);

        // Redirect coincident with ack
        fixed_wait = 0;
        do_reset();
        cycle(1'b0, 1'b0, 32'd0, 1'b0);
        cycle(1'b0, 1'b1, 32'h40, 1'b0);
        check("t4_pcnext", PC_next, 32'h40);
        cycle(1'b0, 1'b0, 32'd0, 1'b0);
        check("t4_novalid", 32'(inst_valid), 32'd0);
        cycle(1'b0, 1'b0, 32'd0, 1'b0);
        check("t4_addr", bus.mem_addr, 32'h40);
        cycle(1'b0, 1'b0, 32'd0, 1'b0);
        check("t4_ipc", inst_pc_o, 32'h40);
        check("t4_inst", inst_o, mem_word(32'h40));

        // Wrap at top of address space, misaligned redirect
        do_reset();
        cycle(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0);
        check("t5_align", PC_next, 32'hFFFF_FFFC);
        cycle(1'b0, 1'b0, 32'd0, 1'b0);
        cycle(1'b0, 1'b0, 32'd0, 1'b0);
        check("t5_wrap_pcw", 32'(PCWrite), 32'd1);
        check("t5_wrap", PC_next, 32'd0);
        cycle(1'b0, 1'b0, 32'd0, 1'b0);
        check("t5_ipc", inst_pc_o, 32'hFFFF_FFFC);
        cycle(1'b0, 1'b1, 32'h103, 1'b0);
        check("t5_pcnext", PC_next, 32'h100);
        cycle(1'b0, 1'b0, 32'd0, 1'b0);
        cycle(1'b0, 1'b0, 32'd0, 1'b0);
`ifdef FETCH_MISALIGN_CHK_EN
        check("t5_mis_set", 32'(misalign_o), 32'd1);
`else
        check("t5_mis_tied", 32'(misalign_o), 32'd0);
`endif
        do_reset();
        cycle(1'b0, 1'b0, 32'd0, 1'b0);
        check("t5_mis_clr", 32'(misalign_o), 32'd0);

        // Stray ack outside WAIT/DRAIN must be ignored
        do_reset();
        stray_ack = 1;
        cycle(1'b0, 1'b0, 32'd0, 1'b0);
        stray_ack = 0;
        cycle(1'b0, 1'b0, 32'd0, 1'b0);
        check("t6_novalid", 32'(inst_valid), 32'd0);
        check("t6_addr", bus.mem_addr, 32'd0);
        cycle(1'b0, 1'b0, 32'd0, 1'b0);
        check("t6_inst", inst_o, mem_word(32'd0));

        // Random traffic against the reference model
        fixed_wait = -1;
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            stray_ack = ($urandom_range(0, 15) == 0);
            cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 7) == 0),
                  $urandom, 1'($urandom_range(0, 1)));
        end
        stray_ack = 0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
